// File: rtl/cdb_arbiter.sv
// Two-source (RS, LSB) common data bus arbiter with a single-entry holding register per source.
// Build option CDB_ROUND_ROBIN_EN: round-robin tie-break; when undefined, LSB wins every tie.
module cdb_arbiter #(
  parameter int ROB_ADDR_W = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  rs_valid_in,
  input  logic [ROB_ADDR_W-1:0] rs_idx_in,
  input  logic [31:0]           rs_value_in,
  output logic                  rs_ready_out,
  input  logic                  lsb_valid_in,
  input  logic [ROB_ADDR_W-1:0] lsb_idx_in,
  input  logic [31:0]           lsb_value_in,
  output logic                  lsb_ready_out,
  output logic                  cdb_valid_out,
  output logic [ROB_ADDR_W-1:0] cdb_idx_out,
  output logic [31:0]           cdb_value_out
);

  localparam int NSRC    = 2;
  localparam int SRC_RS  = 0;
  localparam int SRC_LSB = 1;

  logic [NSRC-1:0]       w_in_valid;
  logic [ROB_ADDR_W-1:0] w_in_idx   [NSRC];
  logic [31:0]           w_in_value [NSRC];

  logic [NSRC-1:0]       w_hold_valid;
  logic [ROB_ADDR_W-1:0] w_hold_idx   [NSRC];
  logic [31:0]           w_hold_value [NSRC];

  logic [NSRC-1:0]       w_grant;
  logic [NSRC-1:0]       w_ready;
  logic [NSRC-1:0]       w_accept;
  logic                  w_advance;
  logic                  w_tie_to_rs;
  logic [ROB_ADDR_W-1:0] w_grant_idx;
  logic [31:0]           w_grant_value;

  logic                  r_cdb_valid;
  logic [ROB_ADDR_W-1:0] r_cdb_idx;
  logic [31:0]           r_cdb_value;

  assign w_in_valid[SRC_RS]  = rs_valid_in;
  assign w_in_idx[SRC_RS]    = rs_idx_in;
  assign w_in_value[SRC_RS]  = rs_value_in;
  assign w_in_valid[SRC_LSB] = lsb_valid_in;
  assign w_in_idx[SRC_LSB]   = lsb_idx_in;
  assign w_in_value[SRC_LSB] = lsb_value_in;

  // State moves only when enabled and not being flushed.
  assign w_advance = rdy_in && !flush_in;

`ifdef CDB_ROUND_ROBIN_EN
  logic r_last_grant_lsb;

  // Starts at LSB so that the first tie after reset goes to RS.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_last_grant_lsb <= 1'b1;
    end else if (w_advance && (|w_grant)) begin
      r_last_grant_lsb <= w_grant[SRC_LSB];
    end
  end

  assign w_tie_to_rs = r_last_grant_lsb;
`else
  assign w_tie_to_rs = 1'b0;
`endif

  always_comb begin
    w_grant = '0;
    case (w_hold_valid)
      2'b01:   w_grant[SRC_RS]  = 1'b1;
      2'b10:   w_grant[SRC_LSB] = 1'b1;
      2'b11: begin
        if (w_tie_to_rs) begin
          w_grant[SRC_RS] = 1'b1;
        end else begin
          w_grant[SRC_LSB] = 1'b1;
        end
      end
      default: w_grant = '0;
    endcase
  end

  assign w_grant_idx   = w_grant[SRC_LSB] ? w_hold_idx[SRC_LSB]   : w_hold_idx[SRC_RS];
  assign w_grant_value = w_grant[SRC_LSB] ? w_hold_value[SRC_LSB] : w_hold_value[SRC_RS];

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      logic                  r_valid;
      logic [ROB_ADDR_W-1:0] r_idx;
      logic [31:0]           r_value;

      // A slot being drained this cycle can take a new result on the same edge.
      assign w_ready[gi]      = rst_in && w_advance && (!r_valid || w_grant[gi]);
      assign w_accept[gi]     = w_in_valid[gi] && w_ready[gi];
      assign w_hold_valid[gi] = r_valid;
      assign w_hold_idx[gi]   = r_idx;
      assign w_hold_value[gi] = r_value;

      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          r_valid <= 1'b0;
          r_idx   <= '0;
          r_value <= '0;
        end else if (rdy_in) begin
          if (flush_in) begin
            r_valid <= 1'b0;
          end else if (w_accept[gi]) begin
            r_valid <= 1'b1;
            r_idx   <= w_in_idx[gi];
            r_value <= w_in_value[gi];
          end else if (w_grant[gi]) begin
            r_valid <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cdb_valid <= 1'b0;
      r_cdb_idx   <= '0;
      r_cdb_value <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_cdb_valid <= 1'b0;
      end else if (|w_grant) begin
        r_cdb_valid <= 1'b1;
        r_cdb_idx   <= w_grant_idx;
        r_cdb_value <= w_grant_value;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign rs_ready_out  = w_ready[SRC_RS];
  assign lsb_ready_out = w_ready[SRC_LSB];
  assign cdb_valid_out = r_cdb_valid;
  assign cdb_idx_out   = r_cdb_idx;
  assign cdb_value_out = r_cdb_value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural model. Follows CDB_ROUND_ROBIN_EN like the design.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  localparam int AW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          flush_in;
  logic          rs_valid_in;
  logic [AW-1:0] rs_idx_in;
  logic [31:0]   rs_value_in;
  logic          rs_ready_out;
  logic          lsb_valid_in;
  logic [AW-1:0] lsb_idx_in;
  logic [31:0]   lsb_value_in;
  logic          lsb_ready_out;
  logic          cdb_valid_out;
  logic [AW-1:0] cdb_idx_out;
  logic [31:0]   cdb_value_out;

  int n_cmp  = 0;
  int n_fail = 0;

  cdb_arbiter #(.ROB_ADDR_W(AW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .rs_valid_in(rs_valid_in), .rs_idx_in(rs_idx_in), .rs_value_in(rs_value_in),
    .rs_ready_out(rs_ready_out),
    .lsb_valid_in(lsb_valid_in), .lsb_idx_in(lsb_idx_in), .lsb_value_in(lsb_value_in),
    .lsb_ready_out(lsb_ready_out),
    .cdb_valid_out(cdb_valid_out), .cdb_idx_out(cdb_idx_out), .cdb_value_out(cdb_value_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          rs_v;
    logic [AW-1:0] rs_i;
    logic [31:0]   rs_d;
    logic          lsb_v;
    logic [AW-1:0] lsb_i;
    logic [31:0]   lsb_d;
    logic          e_rsr;
    logic          e_lsbr;
    logic          e_cv;
    logic [AW-1:0] e_ci;
    logic [31:0]   e_cd;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [AW-1:0] ri, input logic [31:0] rd,
                              input logic lv, input logic [AW-1:0] li, input logic [31:0] ld,
                              input logic er, input logic el, input logic ev,
                              input logic [AW-1:0] ei, input logic [31:0] ed);
    vec_t v;
    v.rs_v = rv;  v.rs_i = ri;  v.rs_d = rd;
    v.lsb_v = lv; v.lsb_i = li; v.lsb_d = ld;
    v.e_rsr = er; v.e_lsbr = el; v.e_cv = ev; v.e_ci = ei; v.e_cd = ed;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: each source owns at most one pending result.
  bit            m_held [2];
  logic [AW-1:0] m_idx  [2];
  logic [31:0]   m_val  [2];
  bit            m_cv;
  logic [AW-1:0] m_ci;
  logic [31:0]   m_cd;
`ifdef CDB_ROUND_ROBIN_EN
  bit            m_last_lsb;
`endif

  task automatic m_reset();
    m_held[0] = 1'b0; m_held[1] = 1'b0;
    m_cv = 1'b0; m_ci = '0; m_cd = '0;
`ifdef CDB_ROUND_ROBIN_EN
    m_last_lsb = 1'b1;
`endif
  endtask

  // Returns 0 for RS, 1 for LSB, -1 for nothing pending.
  function automatic int m_pick();
    if (m_held[0] && m_held[1]) begin
`ifdef CDB_ROUND_ROBIN_EN
      return m_last_lsb ? 0 : 1;
`else
      return 1;
`endif
    end
    if (m_held[0]) return 0;
    if (m_held[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_ready(input int s);
    return rst_in && rdy_in && !flush_in && (!m_held[s] || m_pick() == s);
  endfunction

  task automatic m_step();
    int g;
    bit acc_rs, acc_lsb;
    acc_rs  = rs_valid_in && m_ready(0);
    acc_lsb = lsb_valid_in && m_ready(1);
    g = m_pick();
    if (!rdy_in) return;
    if (flush_in) begin
      m_held[0] = 1'b0; m_held[1] = 1'b0; m_cv = 1'b0;
      return;
    end
    if (g >= 0) begin
      m_cv = 1'b1; m_ci = m_idx[g]; m_cd = m_val[g]; m_held[g] = 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
      m_last_lsb = (g == 1);
`endif
    end else begin
      m_cv = 1'b0;
    end
    if (acc_rs) begin
      m_held[0] = 1'b1; m_idx[0] = rs_idx_in; m_val[0] = rs_value_in;
    end
    if (acc_lsb) begin
      m_held[1] = 1'b1; m_idx[1] = lsb_idx_in; m_val[1] = lsb_value_in;
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0;
    rs_valid_in = 1'b0;  rs_idx_in = '0;  rs_value_in = '0;
    lsb_valid_in = 1'b0; lsb_idx_in = '0; lsb_value_in = '0;
  endtask

  // Leaves time at posedge+1 with reset released: the next edge can accept.
  task automatic do_reset();
    idle();
    #2 rst_in = 1'b0;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    m_reset();
  endtask

  task automatic next_cycle();
    @(posedge clk_in); #1;
  endtask

  task automatic chk_cv(input string name, input logic exp);
    @(negedge clk_in);
    chk1(name, cdb_valid_out, exp);
  endtask

  initial begin
    vec_t vecs[$];
    int   rs_n, lsb_n, exp_i;
    logic acc_rs, acc_lsb;

    // Reset state, with offers present to show ready stays low.
    idle();
    rst_in = 1'b0;
    rs_valid_in = 1'b1; lsb_valid_in = 1'b1;
    #2;
    chk1("reset cdb_valid", cdb_valid_out, 1'b0);
    chk32("reset cdb_idx", 32'(cdb_idx_out), 32'd0);
    chk32("reset cdb_value", cdb_value_out, 32'd0);
    chk1("reset rs_ready", rs_ready_out, 1'b0);
    chk1("reset lsb_ready", lsb_ready_out, 1'b0);
    next_cycle();
    chk1("reset rs_ready held", rs_ready_out, 1'b0);
    chk1("reset cdb_valid held", cdb_valid_out, 1'b0);
    do_reset();

    // Vector table: single offer latency, RS stream 0..7, LSB single, staggered pair.
    vecs.push_back(mk(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b1, 4'd3, 32'h11));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    for (int i = 0; i < 8; i++) begin
      if (i < 2)
        vecs.push_back(mk(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0, 32'h0,
                          1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
      else
        vecs.push_back(mk(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, 4'd0, 32'h0,
                          1'b1, 1'b1, 1'b1, 4'(i - 2), 32'h100 + 32'(i - 2)));
    end
    vecs.push_back(mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b1, 4'd6, 32'h106));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b1, 4'd7, 32'h107));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0, 1'b1, 4'd9, 32'hABC, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b1, 4'd9, 32'hABC));
    vecs.push_back(mk(1'b1, 4'd1, 32'h21, 1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b1, 4'd2, 32'h22, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b1, 4'd1, 32'h21));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b1, 4'd2, 32'h22));
    vecs.push_back(mk(1'b0, 4'd0, 32'h0,  1'b0, 4'd0, 32'h0,  1'b1, 1'b1, 1'b0, 4'd0, 32'h0));

    foreach (vecs[i]) begin
      rs_valid_in  = vecs[i].rs_v;  rs_idx_in  = vecs[i].rs_i;  rs_value_in  = vecs[i].rs_d;
      lsb_valid_in = vecs[i].lsb_v; lsb_idx_in = vecs[i].lsb_i; lsb_value_in = vecs[i].lsb_d;
      @(negedge clk_in);
      chk1($sformatf("vec%0d rs_ready", i), rs_ready_out, vecs[i].e_rsr);
      chk1($sformatf("vec%0d lsb_ready", i), lsb_ready_out, vecs[i].e_lsbr);
      chk1($sformatf("vec%0d cdb_valid", i), cdb_valid_out, vecs[i].e_cv);
      if (vecs[i].e_cv) begin
        chk32($sformatf("vec%0d cdb_idx", i), 32'(cdb_idx_out), 32'(vecs[i].e_ci));
        chk32($sformatf("vec%0d cdb_value", i), cdb_value_out, vecs[i].e_cd);
        $display("vec%0d cdb idx=%0d value=%08h", i, cdb_idx_out, cdb_value_out);
      end
      next_cycle();
    end

    // Both sources offering every cycle.
    do_reset();
    rs_n = 0; lsb_n = 0;
    for (int c = 0; c < 10; c++) begin
      rs_valid_in  = 1'b1; rs_idx_in  = AW'(rs_n);      rs_value_in  = 32'h1000 + 32'(rs_n);
      lsb_valid_in = 1'b1; lsb_idx_in = AW'(8 + lsb_n); lsb_value_in = 32'h2000 + 32'(lsb_n);
      @(negedge clk_in);
      if (c == 0) begin
        chk1("tie c0 rs_ready", rs_ready_out, 1'b1);
        chk1("tie c0 lsb_ready", lsb_ready_out, 1'b1);
      end else begin
`ifdef CDB_ROUND_ROBIN_EN
        chk1($sformatf("tie c%0d rs_ready", c), rs_ready_out, (c % 2) == 1);
        chk1($sformatf("tie c%0d lsb_ready", c), lsb_ready_out, (c % 2) == 0);
`else
        chk1($sformatf("tie c%0d rs_ready", c), rs_ready_out, 1'b0);
        chk1($sformatf("tie c%0d lsb_ready", c), lsb_ready_out, 1'b1);
`endif
      end
      if (c >= 2) begin
`ifdef CDB_ROUND_ROBIN_EN
        exp_i = ((c - 2) % 2 == 0) ? (c - 2) / 2 : 8 + (c - 2) / 2;
`else
        exp_i = 8 + (c - 2);
`endif
        chk1($sformatf("tie c%0d cdb_valid", c), cdb_valid_out, 1'b1);
        chk32($sformatf("tie c%0d cdb_idx", c), 32'(cdb_idx_out), 32'(exp_i));
        $display("tie c%0d cdb idx=%0d value=%08h", c, cdb_idx_out, cdb_value_out);
      end
      acc_rs = rs_ready_out; acc_lsb = lsb_ready_out;
      next_cycle();
      if (acc_rs) rs_n++;
      if (acc_lsb) lsb_n++;
    end

    // Flush with both holding registers full.
    do_reset();
    rs_valid_in = 1'b1;  rs_idx_in = 4'd1;  rs_value_in = 32'hA1;
    lsb_valid_in = 1'b1; lsb_idx_in = 4'd2; lsb_value_in = 32'hA2;
    next_cycle();
    idle();
    flush_in = 1'b1;
    @(negedge clk_in);
    chk1("flush rs_ready low", rs_ready_out, 1'b0);
    chk1("flush lsb_ready low", lsb_ready_out, 1'b0);
    next_cycle();
    flush_in = 1'b0;
    @(negedge clk_in);
    chk1("post-flush rs_ready", rs_ready_out, 1'b1);
    chk1("post-flush lsb_ready", lsb_ready_out, 1'b1);
    chk1("post-flush cdb_valid", cdb_valid_out, 1'b0);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      chk_cv($sformatf("post-flush cdb_valid +%0d", k + 1), 1'b0);
    end
    next_cycle();

    // rdy_in low for three cycles with LSB idx 5 held.
    do_reset();
    lsb_valid_in = 1'b1; lsb_idx_in = 4'd5; lsb_value_in = 32'h55;
    next_cycle();
    lsb_valid_in = 1'b0; rdy_in = 1'b0;
    rs_valid_in = 1'b1; rs_idx_in = 4'd7; rs_value_in = 32'h77;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk1($sformatf("freeze%0d rs_ready", k), rs_ready_out, 1'b0);
      chk1($sformatf("freeze%0d lsb_ready", k), lsb_ready_out, 1'b0);
      chk1($sformatf("freeze%0d cdb_valid", k), cdb_valid_out, 1'b0);
      next_cycle();
    end
    rdy_in = 1'b1; rs_valid_in = 1'b0;
    @(negedge clk_in);
    chk1("unfreeze cdb_valid", cdb_valid_out, 1'b0);
    chk1("unfreeze lsb_ready", lsb_ready_out, 1'b1);
    next_cycle();
    @(negedge clk_in);
    chk1("unfreeze+1 cdb_valid", cdb_valid_out, 1'b1);
    chk32("unfreeze+1 cdb_idx", 32'(cdb_idx_out), 32'd5);
    chk32("unfreeze+1 cdb_value", cdb_value_out, 32'h55);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      chk_cv($sformatf("unfreeze+%0d cdb_valid", k + 2), 1'b0);
    end
    next_cycle();

    // Asynchronous reset between edges while results are held.
    do_reset();
    rs_valid_in = 1'b1; rs_idx_in = 4'd2; rs_value_in = 32'h42;
    next_cycle();
    rs_idx_in = 4'd4; rs_value_in = 32'h44;
    lsb_valid_in = 1'b1; lsb_idx_in = 4'd6; lsb_value_in = 32'h66;
    next_cycle();
    idle();
    @(negedge clk_in);
    chk1("pre-areset cdb_valid", cdb_valid_out, 1'b1);
    chk32("pre-areset cdb_idx", 32'(cdb_idx_out), 32'd2);
    #2 rst_in = 1'b0;
    #1;
    chk1("areset cdb_valid", cdb_valid_out, 1'b0);
    chk32("areset cdb_idx", 32'(cdb_idx_out), 32'd0);
    chk32("areset cdb_value", cdb_value_out, 32'd0);
    chk1("areset rs_ready", rs_ready_out, 1'b0);
    chk1("areset lsb_ready", lsb_ready_out, 1'b0);
    next_cycle();
    rst_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk_cv($sformatf("after areset cdb_valid +%0d", k), 1'b0);
      next_cycle();
    end

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rdy_in       = 1'($urandom_range(0, 9) != 0);
      flush_in     = 1'($urandom_range(0, 19) == 0);
      rs_valid_in  = 1'($urandom_range(0, 1));
      rs_idx_in    = AW'($urandom);
      rs_value_in  = $urandom;
      lsb_valid_in = 1'($urandom_range(0, 1));
      lsb_idx_in   = AW'($urandom);
      lsb_value_in = $urandom;
      @(negedge clk_in);
      chk1($sformatf("rnd%0d rs_ready", c), rs_ready_out, m_ready(0));
      chk1($sformatf("rnd%0d lsb_ready", c), lsb_ready_out, m_ready(1));
      chk1($sformatf("rnd%0d cdb_valid", c), cdb_valid_out, m_cv);
      chk32($sformatf("rnd%0d cdb_idx", c), 32'(cdb_idx_out), 32'(m_ci));
      chk32($sformatf("rnd%0d cdb_value", c), cdb_value_out, m_cd);
      if (cdb_valid_out)
        $display("rnd%0d cdb idx=%0d value=%08h", c, cdb_idx_out, cdb_value_out);
      m_step();
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
